// File: rtl/l0_skew_fifo_pkg.sv
// Shared constants and types for the l0 skew FIFO (default geometry and
// instruction encodings driven toward the mac_tile array).
package l0_pkg;

    localparam int L0_ROW   = 8;
    localparam int L0_BW    = 4;
    localparam int L0_DEPTH = 64;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    // One pop request as it travels down the diagonal skew.
    typedef struct packed {
        logic       rd;
        logic [1:0] inst;
    } skew_t;

endpackage

// File: rtl/l0_skew_fifo_row_fifo.sv
// One FIFO lane: wrap-bit pointers, registered output that holds its value
// when nothing is popped.
module l0_row_fifo #(
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [bw-1:0] in,
    output logic [bw-1:0] out,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(depth);

    logic [AW:0]   wp;
    logic [AW:0]   rp;
    logic [bw-1:0] mem [depth];
    logic          push;
    logic          pop;

    assign o_empty = (wp == rp);
    assign o_full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign push    = wr && !o_full;
    assign pop     = rd && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            out <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp  <= rp + 1'b1;
                out <= mem[rp[AW-1:0]];
            end
        end
    end

    // Storage is left uninitialised by reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= in;
    end

endmodule

// File: rtl/l0_skew_fifo.sv
// Skewed input staging buffer for the systolic array. Define L0_SKEW_EN for
// the one-cycle-per-row diagonal pop; otherwise all lanes pop together.
module l0_skew_fifo
    import l0_pkg::*;
#(
    parameter int row   = L0_ROW,
    parameter int bw    = L0_BW,
    parameter int depth = L0_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [row*bw-1:0] in,
    input  logic              rd,
    input  logic [1:0]        inst,
    output logic [row*bw-1:0] out,
    output logic [2*row-1:0]  inst_out,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_ready
);
    skew_t          live;
    skew_t          req [row];
    logic [row-1:0] lane_full;
    logic [row-1:0] lane_empty;
    logic           wr_ok;

    always_comb begin
        live      = '0;
        live.rd   = rd;
        live.inst = inst;
    end

`ifdef L0_SKEW_EN
    // Lane 0 uses the live request; lane i sees it i edges later.
    skew_t stage [1:row-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < row; i++) stage[i] <= '0;
        end else begin
            stage[1] <= live;
            for (int i = 2; i < row; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        req[0] = live;
        for (int i = 1; i < row; i++) req[i] = stage[i];
    end
`else
    always_comb begin
        for (int i = 0; i < row; i++) req[i] = live;
    end
`endif

    // Full is judged on pre-edge state, so a pop never makes room same-cycle.
    assign o_full  = |lane_full;
    assign o_empty = &lane_empty;
    assign o_ready = !o_full;
    assign wr_ok   = wr && !o_full;

    for (genvar g = 0; g < row; g++) begin : g_lane
        l0_row_fifo #(.bw(bw), .depth(depth)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr_ok),
            .rd      (req[g].rd),
            .in      (in[bw*g +: bw]),
            .out     (out[bw*g +: bw]),
            .o_full  (lane_full[g]),
            .o_empty (lane_empty[g])
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                inst_out[2*g +: 2] <= INST_NOP;
            else if (req[g].rd && !lane_empty[g])
                inst_out[2*g +: 2] <= req[g].inst;
            else
                inst_out[2*g +: 2] <= INST_NOP;
        end
    end

endmodule

// File: tb/tb_l0_skew_fifo.sv
// Directed bench for l0_skew_fifo: a vector table for the basic skewed pop,
// hand sequences for fill/drop, empty pop, streaming and mid-drain reset.
module tb_l0_skew_fifo;
    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;
    localparam int W     = ROW * BW;
`ifdef L0_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif

    logic           clk;
    logic           reset;
    logic           wr;
    logic [W-1:0]   in_v;
    logic           rd;
    logic [1:0]     inst;
    logic [W-1:0]   out_v;
    logic [2*ROW-1:0] inst_out;
    logic           o_full;
    logic           o_empty;
    logic           o_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    l0_skew_fifo #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .in       (in_v),
        .rd       (rd),
        .inst     (inst),
        .out      (out_v),
        .inst_out (inst_out),
        .o_full   (o_full),
        .o_empty  (o_empty),
        .o_ready  (o_ready)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: accepted vectors, per-lane occupancy and read index
    logic [W-1:0]     exp_q[$];
    int               cnt  [ROW];
    int               ridx [ROW];
    logic [2:0]       hist [ROW];
    logic [W-1:0]     m_out;
    logic [2*ROW-1:0] m_inst;

    function automatic bit model_full();
        bit f = 1'b0;
        for (int i = 0; i < ROW; i++) if (cnt[i] == DEPTH) f = 1'b1;
        return f;
    endfunction

    function automatic bit model_empty();
        bit e = 1'b1;
        for (int i = 0; i < ROW; i++) if (cnt[i] != 0) e = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ROW; i++) begin
            cnt[i]  = 0;
            ridx[i] = 0;
            hist[i] = '0;
        end
        exp_q.delete();
        m_out  = '0;
        m_inst = '0;
    endtask

    task automatic model_edge();
        bit full_pre;
        full_pre = model_full();
        for (int i = ROW - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {rd, inst};
        m_inst = '0;
        for (int i = 0; i < ROW; i++) begin
            logic [2:0]   r;
            logic [W-1:0] v;
            r = (SKEW != 0) ? hist[i] : hist[0];
            if (r[2] && cnt[i] > 0) begin
                v = exp_q[ridx[i]];
                m_out[BW*i +: BW] = v[BW*i +: BW];
                m_inst[2*i +: 2]  = r[1:0];
                ridx[i]++;
                cnt[i]--;
            end
        end
        if (wr && !full_pre) begin
            exp_q.push_back(in_v);
            for (int i = 0; i < ROW; i++) cnt[i]++;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: one clock edge, then sample and score against the model
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("out", out_v, m_out);
        check("inst_out", inst_out, m_inst);
        check("o_full", o_full, model_full());
        check("o_empty", o_empty, model_empty());
        check("o_ready", o_ready, !model_full());
    endtask

    task automatic idle();
        wr = 1'b0; rd = 1'b0; inst = 2'b00; in_v = '0;
    endtask

    typedef struct {
        logic           wr;
        logic [W-1:0]   in;
        logic           rd;
        logic [1:0]     inst;
        logic [W-1:0]   exp_out;
        logic [2*ROW-1:0] exp_inst;
        logic           exp_empty;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // reset
        reset = 1'b1;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out_v, '0);
        check("rst_inst_out", inst_out, '0);
        check("rst_empty", o_empty, 1'b1);
        check("rst_full", o_full, 1'b0);
        check("rst_ready", o_ready, 1'b1);
        reset = 1'b0;
        step();

        // table: write lane-index vector, then one rd with EXEC
        tbl[0] = '{wr: 1'b1, in: 32'h7654_3210, rd: 1'b0, inst: 2'b00,
                   exp_out: '0, exp_inst: '0, exp_empty: 1'b0};
        for (int j = 0; j < 10; j++) begin
            logic [W-1:0]     eo;
            logic [2*ROW-1:0] ei;
            eo = '0;
            ei = '0;
            for (int i = 0; i < ROW; i++) begin
                if (SKEW == 0 || i <= j) eo[BW*i +: BW] = BW'(i);
                if ((SKEW != 0) ? (i == j) : (j == 0)) ei[2*i +: 2] = 2'b10;
            end
            tbl[j+1] = '{wr: 1'b0, in: '0, rd: (j == 0), inst: (j == 0) ? 2'b10 : 2'b00,
                         exp_out: eo, exp_inst: ei,
                         exp_empty: (SKEW != 0) ? (j >= ROW - 1) : 1'b1};
        end
        for (int n = 0; n < 11; n++) begin
            wr = tbl[n].wr; in_v = tbl[n].in; rd = tbl[n].rd; inst = tbl[n].inst;
            step();
            check("tbl_out", out_v, tbl[n].exp_out);
            check("tbl_inst_out", inst_out, tbl[n].exp_inst);
            check("tbl_empty", o_empty, tbl[n].exp_empty);
        end
        idle();

        // fill to full, then a dropped write
        wr = 1'b1; in_v = {ROW{4'hA}};
        repeat (DEPTH) step();
        check("fill_full", o_full, 1'b1);
        check("fill_ready", o_ready, 1'b0);
        in_v = {ROW{4'h5}};
        step();
        check("drop_full", o_full, 1'b1);
        idle();
        rd = 1'b1; inst = 2'b01;
        repeat (DEPTH) step();
        rd = 1'b0; inst = 2'b00;
        repeat (ROW + 1) step();
        check("drain_empty", o_empty, 1'b1);
        check("drain_last_out", out_v, {ROW{4'hA}});

        // empty pop: nothing moves, outputs hold
        rd = 1'b1; inst = 2'b01;
        step();
        idle();
        repeat (ROW) step();
        check("epop_empty", o_empty, 1'b1);
        check("epop_out_held", out_v, {ROW{4'hA}});

        // streaming with wrap-around
        for (int c = 0; c < 202; c++) begin
            for (int i = 0; i < ROW; i++) in_v[BW*i +: BW] = BW'(c + i);
            wr = 1'b1;
            rd = (c >= 2);
            inst = (c[0]) ? 2'b10 : 2'b01;
            step();
        end
        wr = 1'b0; rd = 1'b1; inst = 2'b10;
        repeat (2 * ROW + 4) step();
        idle();
        repeat (ROW) step();
        check("stream_empty", o_empty, 1'b1);

`ifndef L0_SKEW_EN
        // unskewed: all lanes present vector 0 one cycle after rd
        wr = 1'b1; in_v = 32'h1357_9bdf; step();
        in_v = 32'h2468_ace0; step();
        in_v = 32'h0f1e_2d3c; step();
        idle();
        rd = 1'b1; inst = 2'b10;
        step();
        idle();
        check("noskew_out", out_v, 32'h1357_9bdf);
        check("noskew_inst", inst_out, {ROW{2'b10}});
        repeat (3) step();
`endif

        // reset mid-drain while lane 3 is popping
        wr = 1'b1; in_v = 32'hc3c3_c3c3; step();
        in_v = 32'h9a9a_9a9a; step();
        idle();
        rd = 1'b1; inst = 2'b01;
        step();
        rd = 1'b0; inst = 2'b00;
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out", out_v, '0);
        check("mid_rst_inst_out", inst_out, '0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_rst_empty", o_empty, 1'b1);
        repeat (ROW + 2) step();
        check("post_rst_inst_quiet", inst_out, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/l0_skew_fifo.md
# l0_skew_fifo

Input staging buffer sitting directly west of the systolic array of `mac_tile` instances. Accepts one activation/weight vector per write (one `bw`-bit element per array row), stores it in per-row FIFOs, and on read presents the elements to each row's `in_w`/`inst_w` with a one-cycle-per-row diagonal skew. The skew is the wavefront the array expects. Row 0 fires first and row `row-1` fires `row-1` cycles later, with the 2-bit instruction travelling alongside its data.

## Interface
- `row`, 8: number of array rows (FIFO lanes).
- `bw`, 4: element width, matching `mac_tile` `bw`.
- `depth`, 64: entries per lane; must be a power of two, ≥ 2.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `wr` input 1: push `in` into all lanes.
- `in` input `row*bw`: lane i at bits `[bw*(i+1)-1 : bw*i]`.
- `rd` input 1: start a skewed pop of one vector.
- `inst` input 2: instruction for this pop (`[1]` execute, `[0]` kernel load).
- `out` output `row*bw`: per-row data to the array `in_w`.
- `inst_out` output `2*row`: per-row instruction to the array `inst_w`.
- `o_full` output 1: any lane full.
- `o_empty` output 1: all lanes empty.
- `o_ready` output 1: `!o_full`.

## Operation
- Each lane has its own write pointer and read pointer, each `log2(depth)+1` bits. The MSB is the wrap bit.
  - Lane empty: pointers are equal.
  - Lane full: low bits are equal and the MSBs differ.
- Write:
  - `wr & !o_full` pushes lane i element into lane i, for all lanes at once.
  - `wr & o_full` drops the whole vector. No pointer moves.
- Skew pipeline: a `row`-deep shift register of {rd, inst}.
  - Stage 0 is loaded from `rd`/`inst` each cycle.
  - Stage i feeds lane i.
- Lane i pops when its stage is 1 and the lane is not empty.
- A pop on an empty lane has these effects:
  - The pointer does not move.
  - `out` for that lane holds its previous value.
  - `inst_out` for that lane is forced to 2'b00.
- Non-popping lanes drive `inst_out` = 2'b00 and hold `out`.
- Simultaneous write and pop on the same lane are both performed. `o_full` is evaluated on pre-edge state, so a write while full is rejected even if a pop occurs that cycle.
- Write and pop on an empty lane in the same cycle:
  - The pop is an empty-pop.
  - There is no write-through bypass.
- `o_full`: OR of the lane fulls. Lane `row-1` drains last, so it is normally the one that determines full.
- `o_empty`: AND of the lane empties.
- Reset, asynchronous and allowed mid-operation, clears:
  - all pointers;
  - the skew pipeline;
  - `out` = 0 and `inst_out` = 0;
  - the flags, giving `o_empty` = 1, `o_full` = 0, `o_ready` = 1.
  - Stored RAM contents need not be cleared.

## Timing
- `rd`/`inst` are sampled at edge k.
- Lane i pops at edge k+i. Its `out`/`inst_out` are valid in the cycle after edge k+i, a latency of 1+i cycles.
- Back-to-back `rd` gives one vector per cycle on every lane after the fill-up period.
- A drain of N vectors completes at edge k+N-1+row-1.
- `o_full`/`o_empty` are registered-state derived. They update the cycle after the causing edge.

## Configuration
- `L0_SKEW_EN` defined: the diagonal skew described above.
- `L0_SKEW_EN` undefined:
  - The skew register is removed.
  - All lanes pop at edge k from `rd`/`inst` directly, and every lane has latency 1.
  - Full, empty and drop rules are unchanged.

## Structure
- Package `l0_pkg` holds:
  - default constants `L0_ROW`, `L0_BW`, `L0_DEPTH`;
  - the inst encodings `INST_NOP` = 2'b00, `INST_LOAD` = 2'b01, `INST_EXEC` = 2'b10.
- Sub-module `l0_row_fifo` implements one lane:
  - ports: `clk`, `reset`, `wr`, `rd`, `in`, `out`, `o_full`, `o_empty`;
  - it is instantiated `row` times.
- The skew pipeline and the flag reduction live in the top module.

## Test plan
- **Reset then skewed pop.** After reset, check `o_empty`=1, `o_ready`=1, `out`=0. Write lanes=0..7 (value = lane index), then pulse `rd` with `inst`=2'b10. Required: lane i shows value i with `inst_out`=2'b10 exactly 1+i cycles after the `rd` edge, and 2'b00 otherwise.
- **Fill to full and drop.** Perform 64 writes of value 4'hA. Required: `o_full`=1 and `o_ready`=0. Then perform a 65th write of 4'h5. Then do 64 `rd`. Required: every lane returns only 4'hA, never 4'h5.
- **Empty pop.** From empty, assert `rd`/`inst`=2'b01. Required: all `inst_out`=00, `out` unchanged, and pointers unchanged (`o_empty` stays 1).
- **Wrap-around streaming.** Hold `wr` and `rd` continuously for 200 cycles with an incrementing pattern. Required: each lane outputs the sequence in order and offset by lane index, and never flags full or empty after fill-up.
- **Reset mid-drain.** Assert `reset` asynchronously while lane 3 of 8 is popping. Required: `out`/`inst_out` go to 0 immediately. After release, `o_empty`=1 and no residual pops.
- **`L0_SKEW_EN` undefined build.** Write 3 vectors and issue one `rd`. Required: all 8 lanes present vector 0 in the same cycle, 1 cycle after `rd`.
